// File: rtl/smm_stream_loader.sv
// Stream-to-operand loader for the SMM1 4x4 multiplier: collects a 2*NELEM word frame
// (A then B), pulses load once, and holds the stream off until the multiplier reports done.
module smm_stream_loader #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned NELEM     = 16,
  parameter int unsigned CNTW      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATAWIDTH-1:0]       s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  input  logic                       mm_done,
  output logic [DATAWIDTH*NELEM-1:0] A_out,
  output logic [DATAWIDTH*NELEM-1:0] B_out,
  output logic                       load,
  output logic                       busy,
  output logic                       frame_err,
  output logic [CNTW-1:0]            frame_cnt
);

  localparam int unsigned IDXW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NELEM - 1);

  typedef enum logic [1:0] {
    ST_RX_A,
    ST_RX_B,
    ST_FIRE,
    ST_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                load_d;
  logic                frame_err_d;
  logic                wr_a, wr_b;
  logic                accept;
  logic [DATAWIDTH-1:0] a_stage [NELEM];
  logic [DATAWIDTH-1:0] b_stage [NELEM];

  assign s_ready = !rst && ((state_q == ST_RX_A) || (state_q == ST_RX_B));
  assign busy    = (state_q == ST_FIRE) || (state_q == ST_WAIT);
  assign accept  = s_valid && s_ready;

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
    wr_a        = 1'b0;
    wr_b        = 1'b0;
    case (state_q)
      ST_RX_A: begin
        if (accept) begin
          if (s_last) begin
            frame_err_d = 1'b1;
            state_d     = ST_RX_A;
            idx_d       = '0;
          end else begin
            wr_a = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_RX_B;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end
        end
      end
      ST_RX_B: begin
        if (accept) begin
          if ((idx_q == LAST_IDX) && s_last) begin
            wr_b    = 1'b1;
            state_d = ST_FIRE;
            idx_d   = '0;
          end else if ((idx_q != LAST_IDX) && !s_last) begin
            wr_b  = 1'b1;
            idx_d = idx_q + IDXW'(1);
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_RX_A;
            idx_d       = '0;
          end
        end
      end
      ST_FIRE: begin
        load_d  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // load is still high in the first WAIT cycle; a done seen then is stale
        if (!load && mm_done) begin
          state_d = ST_RX_A;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_RX_A;
        idx_d   = '0;
      end
    endcase
  end

  // State, staging and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RX_A;
      idx_q     <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      A_out     <= '0;
      B_out     <= '0;
      for (int i = 0; i < int'(NELEM); i++) begin
        a_stage[i] <= '0;
        b_stage[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      load      <= load_d;
      frame_err <= frame_err_d;
      if (wr_a) a_stage[idx_q] <= s_data;
      if (wr_b) b_stage[idx_q] <= s_data;
      if (state_q == ST_FIRE) begin
        for (int i = 0; i < int'(NELEM); i++) begin
          A_out[i*DATAWIDTH +: DATAWIDTH] <= a_stage[i];
          B_out[i*DATAWIDTH +: DATAWIDTH] <= b_stage[i];
        end
        frame_cnt <= frame_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_smm_stream_loader.sv
// Randomized self-checking bench for smm_stream_loader against a frame-level model.
module tb_smm_stream_loader;
  localparam int unsigned DW = 32;
  localparam int unsigned NE = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = DW * NE;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          mm_done;
  logic [BW-1:0] A_out;
  logic [BW-1:0] B_out;
  logic          load;
  logic          busy;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int load_pulses = 0;
  int err_pulses = 0;

  logic [DW-1:0] fw [2*NE];
  logic [BW-1:0] exp_a, exp_b;
  int            exp_cnt;

  smm_stream_loader #(.DATAWIDTH(DW), .NELEM(NE), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .mm_done(mm_done), .A_out(A_out), .B_out(B_out),
    .load(load), .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) load_pulses++;
    if (frame_err) err_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [BW-1:0] pack(input int base);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NE); i++) v[i*DW +: DW] = fw[base+i];
    return v;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < int'(2*NE); i++) fw[i] = $urandom;
  endtask

  // Sends fw[0..n_words-1]; s_last on word last_pos. Returns just after the last handshake.
  task automatic send_frame(input int n_words, input int last_pos, input bit gaps);
    int t;
    for (int i = 0; i < n_words; i++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = fw[i];
      s_last  = (i == last_pos);
      t = 0;
      while (!s_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word %0d never accepted (s_ready=%b, required 1)", i, s_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic release_done(input int delay);
    repeat (delay) @(negedge clk);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; mm_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", s_ready); end
    checks++;
    if (load !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: load=%b frame_err=%b busy=%b required 0 0 0", load, frame_err, busy);
    end
    checks++;
    if (A_out !== '0 || B_out !== '0 || frame_cnt !== '0) begin
      errors++; $display("FAIL reset_outs: A0=%h B0=%h cnt=%0d required zeros", A_out[DW-1:0], B_out[DW-1:0], frame_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", s_ready); end
    exp_a = '0; exp_b = '0; exp_cnt = 0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < int'(NE); i++) begin
      fw[i]    = DW'(i + 1);
      fw[NE+i] = DW'(32'h16 - i);
    end
    send_frame(2*NE, 2*NE-1, 1'b0);
    checks++;
    if (load !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL fire_cycle: load=%b busy=%b s_ready=%b required 0 1 0", load, busy, s_ready);
    end
    @(negedge clk);
    exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
    checks++;
    if (load !== 1'b1) begin errors++; $display("FAIL basic_load: got %b required 1", load); end
    checks++;
    if (A_out[DW-1:0] !== 32'h1 || A_out[15*DW +: DW] !== 32'h10 || B_out[DW-1:0] !== 32'h16) begin
      errors++; $display("FAIL basic_elems: A0=%h A15=%h B0=%h required 1 10 16",
                         A_out[DW-1:0], A_out[15*DW +: DW], B_out[DW-1:0]);
    end
    checks++;
    if (A_out !== exp_a || B_out !== exp_b) begin
      errors++; $display("FAIL basic_bus: A=%h B=%h required A=%h B=%h", A_out, B_out, exp_a, exp_b);
    end
    checks++;
    if (frame_cnt !== CW'(exp_cnt) || busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL basic_status: cnt=%0d busy=%b s_ready=%b required %0d 1 0",
                         frame_cnt, busy, s_ready, CW'(exp_cnt));
    end
    @(negedge clk);
    checks++;
    if (load !== 1'b0) begin errors++; $display("FAIL basic_load_width: got %b required 0", load); end
    release_done(2);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_release: s_ready=%b busy=%b required 1 0", s_ready, busy);
    end
  endtask

  task automatic test_gaps();
    for (int f = 0; f < 4; f++) begin
      if (f > 0) rand_frame();
      send_frame(2*NE, 2*NE-1, 1'b1);
      @(negedge clk);
      exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
      checks++;
      if (load !== 1'b1 || A_out !== exp_a || B_out !== exp_b || frame_cnt !== CW'(exp_cnt)) begin
        errors++; $display("FAIL gaps_frame%0d: load=%b cnt=%0d A=%h B=%h required 1 %0d A=%h B=%h",
                           f, load, frame_cnt, A_out, B_out, CW'(exp_cnt), exp_a, exp_b);
      end
      release_done(1 + int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_wait_hold();
    rand_frame();
    send_frame(2*NE, 2*NE-1, 1'b0);
    exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
    s_valid = 1'b1; s_data = 32'hDEAD; s_last = 1'b0;
    @(negedge clk);
    mm_done = 1'b1;
    checks++;
    if (load !== 1'b1) begin errors++; $display("FAIL hold_load: got %b required 1", load); end
    @(negedge clk);
    mm_done = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_stale_done: s_ready=%b busy=%b required 0 1", s_ready, busy);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL hold_wait%0d: s_ready=%b required 0", k, s_ready); end
    end
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL hold_release: s_ready=%b required 1", s_ready); end
    rand_frame();
    fw[0] = 32'hDEAD;
    send_frame(2*NE, 2*NE-1, 1'b0);
    @(negedge clk);
    exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
    checks++;
    if (load !== 1'b1 || A_out[DW-1:0] !== 32'hDEAD || A_out !== exp_a || B_out !== exp_b) begin
      errors++; $display("FAIL hold_dead_frame: load=%b A0=%h A=%h required 1 dead A=%h", load, A_out[DW-1:0], A_out, exp_a);
    end
    release_done(1);
  endtask

  task automatic test_early_last();
    int pos [4] = '{9, 20, 15, 0};
    int l0, e0;
    for (int p = 0; p < 4; p++) begin
      rand_frame();
      l0 = load_pulses; e0 = err_pulses;
      send_frame(pos[p] + 1, pos[p], 1'b0);
      checks++;
      if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err%0d: frame_err=%b required 1", pos[p], frame_err); end
      repeat (4) @(negedge clk);
      checks++;
      if (load_pulses !== l0 || err_pulses !== e0 + 1 || s_ready !== 1'b1) begin
        errors++; $display("FAIL early_side%0d: loads=%0d errs=%0d s_ready=%b required %0d %0d 1",
                           pos[p], load_pulses - l0, err_pulses - e0, s_ready, 0, 1);
      end
      checks++;
      if (A_out !== exp_a || B_out !== exp_b || frame_cnt !== CW'(exp_cnt)) begin
        errors++; $display("FAIL early_hold%0d: cnt=%0d A=%h required %0d A=%h", pos[p], frame_cnt, A_out, CW'(exp_cnt), exp_a);
      end
    end
    rand_frame();
    send_frame(2*NE, 2*NE-1, 1'b0);
    @(negedge clk);
    exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
    checks++;
    if (load !== 1'b1 || A_out !== exp_a || B_out !== exp_b || frame_cnt !== CW'(exp_cnt)) begin
      errors++; $display("FAIL early_recover: load=%b cnt=%0d A=%h required 1 %0d A=%h", load, frame_cnt, A_out, CW'(exp_cnt), exp_a);
    end
    release_done(1);
  endtask

  task automatic test_missing_last();
    int l0;
    rand_frame();
    l0 = load_pulses;
    send_frame(2*NE, -1, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL nolast_err: frame_err=%b required 1", frame_err); end
    repeat (3) @(negedge clk);
    checks++;
    if (load_pulses !== l0 || A_out !== exp_a || frame_cnt !== CW'(exp_cnt)) begin
      errors++; $display("FAIL nolast_side: loads=%0d cnt=%0d required 0 %0d", load_pulses - l0, frame_cnt, CW'(exp_cnt));
    end
    rand_frame();
    send_frame(2*NE, 2*NE-1, 1'b0);
    @(negedge clk);
    exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
    checks++;
    if (load !== 1'b1 || A_out !== exp_a || B_out !== exp_b) begin
      errors++; $display("FAIL nolast_next: load=%b A0=%h required 1 %h", load, A_out[DW-1:0], fw[0]);
    end
    release_done(1);
  endtask

  task automatic test_mid_reset();
    rand_frame();
    send_frame(20, -1, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", s_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_a = '0; exp_b = '0; exp_cnt = 0;
    checks++;
    if (A_out !== exp_a || B_out !== exp_b || frame_cnt !== CW'(exp_cnt) || load !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state: A0=%h B0=%h cnt=%0d load=%b s_ready=%b required 0 0 0 0 1",
                         A_out[DW-1:0], B_out[DW-1:0], frame_cnt, load, s_ready);
    end
    rand_frame();
    send_frame(2*NE, 2*NE-1, 1'b0);
    @(negedge clk);
    exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
    checks++;
    if (load !== 1'b1 || A_out !== exp_a || B_out !== exp_b || frame_cnt !== CW'(exp_cnt)) begin
      errors++; $display("FAIL midrst_frame: load=%b cnt=%0d A=%h required 1 %0d A=%h", load, frame_cnt, A_out, CW'(exp_cnt), exp_a);
    end
    release_done(1);
  endtask

  task automatic test_cnt_wrap();
    for (int f = 0; f < 258; f++) begin
      rand_frame();
      send_frame(2*NE, 2*NE-1, 1'b0);
      @(negedge clk);
      exp_a = pack(0); exp_b = pack(NE); exp_cnt++;
      checks++;
      if (load !== 1'b1 || frame_cnt !== CW'(exp_cnt) || A_out !== exp_a || B_out !== exp_b) begin
        errors++; $display("FAIL wrap_frame%0d: load=%b cnt=%0d required 1 %0d", f, load, frame_cnt, CW'(exp_cnt));
      end
      release_done(1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wait_hold();
    test_early_last();
    test_missing_last();
    test_mid_reset();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
